// File: rtl/mem_pkg.sv
// Shared types for the load/store front-end: access sizes, FSM states and
// the alignment rule used at request accept.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } mem_size_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } mau_state_t;

    localparam int BYTES_PER_WORD = 4;

    // True when the access can never reach the RAM: bad size or misaligned.
    function automatic logic access_err(input mem_size_t size, input logic [1:0] offset);
        case (size)
            SZ_HALF: return offset[0];
            SZ_WORD: return offset != 2'b00;
            SZ_ILL:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering for a 32-bit little-endian word: extracts and extends
// load data, and merges sub-word store data into an old word.
module mau_lane
    import mem_pkg::*;
(
    input  logic [31:0] ld_word,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        is_signed,
    input  logic [31:0] st_old,
    input  logic [31:0] st_new,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // NOTE: every output gets a default before the case so no path can leave
    // a value unassigned and infer a latch.
    always_comb begin
        ld_byte = ld_word[7:0];
        case (offset)
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            2'd3:    ld_byte = ld_word[31:24];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = offset[1] ? ld_word[31:16] : ld_word[15:0];

        ld_data = ld_word;
        case (size)
            SZ_BYTE: ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
            default: ld_data = ld_word;
        endcase
    end

    always_comb begin
        st_word = st_old;
        case (size)
            SZ_BYTE: begin
                case (offset)
                    2'd1:    st_word[15:8]  = st_new[7:0];
                    2'd2:    st_word[23:16] = st_new[7:0];
                    2'd3:    st_word[31:24] = st_new[7:0];
                    default: st_word[7:0]   = st_new[7:0];
                endcase
            end
            SZ_HALF: begin
                if (offset[1]) st_word[31:16] = st_new[15:0];
                else           st_word[15:0]  = st_new[15:0];
            end
            default: st_word = st_new;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end driving a word-wide single-port RAM with one-cycle
// read latency. Optional request counters are enabled by MAU_STATS_EN.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
`ifdef MAU_STATS_EN
    output logic [15:0]       stat_loads,
    output logic [15:0]       stat_stores,
    output logic [15:0]       stat_errs,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int OFF_W = $clog2(BYTES_PER_WORD);

    mau_state_t        state;
    logic              cap_we;
    logic              cap_signed;
    mem_size_t         cap_size;
    logic [OFF_W-1:0]  cap_off;
    logic [DATA_W-1:0] cap_wdata;
    mem_size_t         req_sz;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] st_word;

    assign req_sz    = mem_size_t'(req_size);
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    // The old word for a read-modify-write is the same RAM read a load uses.
    mau_lane u_lane (
        .ld_word   (ram_rdata),
        .offset    (cap_off),
        .size      (cap_size),
        .is_signed (cap_signed),
        .st_old    (ram_rdata),
        .st_new    (cap_wdata),
        .ld_data   (ld_data),
        .st_word   (st_word)
    );

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cap_we     <= 1'b0;
            cap_signed <= 1'b0;
            cap_size   <= SZ_BYTE;
            cap_off    <= '0;
            cap_wdata  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        cap_we     <= req_we;
                        cap_signed <= req_signed;
                        cap_size   <= req_sz;
                        cap_off    <= req_addr[OFF_W-1:0];
                        cap_wdata  <= req_wdata;
                        if (access_err(req_sz, req_addr[OFF_W-1:0])) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= ST_RESP;
                        end else if (req_we && req_sz == SZ_WORD) begin
                            ram_addr  <= req_addr[ADDR_W+1:OFF_W];
                            ram_wdata <= req_wdata;
                            ram_we    <= 1'b1;
                            state     <= ST_WR;
                        end else begin
                            ram_addr <= req_addr[ADDR_W+1:OFF_W];
                            state    <= ST_RD;
                        end
                    end
                end
                ST_RD: state <= ST_WAIT;
                ST_WAIT: begin
                    if (cap_we) begin
                        ram_wdata <= st_word;
                        ram_we    <= 1'b1;
                        state     <= ST_WR;
                    end else begin
                        rsp_rdata <= ld_data;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    ram_we    <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    state     <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MAU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (state == ST_RESP) begin
            if (rsp_err) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (cap_we) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule
